// File: rtl/gate_eval_pkg.sv
// Shared types and truth-table constants for the bit-serial 2-input gate evaluator.
package gate_eval_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Truth tables are indexed by {a_bit, b_bit}.
    localparam logic [3:0] FN_AND  = 4'b1000;
    localparam logic [3:0] FN_OR   = 4'b1110;
    localparam logic [3:0] FN_NAND = 4'b0111;
    localparam logic [3:0] FN_NOR  = 4'b0001;
    localparam logic [3:0] FN_XOR  = 4'b0110;
    localparam logic [3:0] FN_XNOR = 4'b1001;

endpackage

// File: rtl/gate_lut2.sv
// Single-bit 2-input lookup: the result is the truth-table bit selected by {a, b}.
module gate_lut2 (
    input  logic [3:0] func,
    input  logic       a,
    input  logic       b,
    output logic       s
);

    assign s = func[{a, b}];

endmodule

// File: rtl/gate_eval_serial.sv
// Bit-serial evaluator of any 2-input boolean function, LANES bits per cycle.
// Optional ones-count output enabled by defining GATE_EVAL_POPCNT_EN.
module gate_eval_serial
    import gate_eval_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [3:0]                   func,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             s
`ifdef GATE_EVAL_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0]   pop
`endif
);

    localparam int N     = WIDTH / LANES;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = $clog2(WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [3:0]       func_r;
    logic [WIDTH-1:0] shreg_r;
    logic [LANES-1:0] a_chunk_s;
    logic [LANES-1:0] b_chunk_s;
    logic [LANES-1:0] chunk_s;
    logic [WIDTH-1:0] next_shreg_s;

    // Select the operand chunk currently being evaluated.
    always_comb begin
        a_chunk_s = a_r[idx_r*LANES +: LANES];
        b_chunk_s = b_r[idx_r*LANES +: LANES];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gate_lut2 u_lut (
            .func (func_r),
            .a    (a_chunk_s[i]),
            .b    (b_chunk_s[i]),
            .s    (chunk_s[i])
        );
    end

    // Result register with the current chunk merged in; on the last chunk this is the full result.
    always_comb begin
        next_shreg_s = shreg_r;
        next_shreg_s[idx_r*LANES +: LANES] = chunk_s;
    end

`ifdef GATE_EVAL_POPCNT_EN
    logic [PW-1:0] pop_acc_r;
    logic [PW-1:0] pop_next_s;

    function automatic logic [PW-1:0] chunk_ones(input logic [LANES-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + PW'(v[i]);
        end
        return c;
    endfunction

    // Running ones-count including the chunk evaluated this cycle.
    always_comb begin
        pop_next_s = pop_acc_r + chunk_ones(chunk_s);
    end

    // Accumulator restarts on acceptance; pop is only republished on the final chunk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_acc_r <= '0;
            pop       <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        pop_acc_r <= '0;
                    end
                end
                RUN: begin
                    pop_acc_r <= pop_next_s;
                    if (idx_r == LAST_IDX) begin
                        pop <= pop_next_s;
                    end
                end
                default: begin
                    pop_acc_r <= '0;
                end
            endcase
        end
    end
`endif

    // Control FSM: capture on accepted start, one chunk per RUN edge, publish and pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            func_r  <= 4'd0;
            shreg_r <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        func_r  <= func;
                        idx_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    shreg_r <= next_shreg_s;
                    if (idx_r == LAST_IDX) begin
                        s       <= next_shreg_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        idx_r   <= '0;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    idx_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_eval_serial.sv
// Self-checking bench: three evaluator instances (LANES = 1, 4, 8) against a minterm-expansion model.
module tb_gate_eval_serial;
    import gate_eval_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a_v = 8'h00;
    logic [7:0] b_v = 8'h00;
    logic [3:0] func_v = 4'h0;
    logic       start_v [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic [7:0] s_w     [3];
    logic [3:0] pop_w   [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_eval_serial #(.WIDTH(8), .LANES(1)) u1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .a(a_v), .b(b_v), .func(func_v),
        .busy(busy_w[0]), .done(done_w[0]), .s(s_w[0])
`ifdef GATE_EVAL_POPCNT_EN
        , .pop(pop_w[0])
`endif
    );
    gate_eval_serial #(.WIDTH(8), .LANES(4)) u4 (
        .clk(clk), .reset(reset), .start(start_v[1]), .a(a_v), .b(b_v), .func(func_v),
        .busy(busy_w[1]), .done(done_w[1]), .s(s_w[1])
`ifdef GATE_EVAL_POPCNT_EN
        , .pop(pop_w[1])
`endif
    );
    gate_eval_serial #(.WIDTH(8), .LANES(8)) u8 (
        .clk(clk), .reset(reset), .start(start_v[2]), .a(a_v), .b(b_v), .func(func_v),
        .busy(busy_w[2]), .done(done_w[2]), .s(s_w[2])
`ifdef GATE_EVAL_POPCNT_EN
        , .pop(pop_w[2])
`endif
    );

    // Minterm expansion of the truth table over whole words.
    function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] f);
        logic [7:0] r;
        r = 8'h00;
        if (f[3]) r = r | (x & y);
        if (f[2]) r = r | (x & ~y);
        if (f[1]) r = r | (~x & y);
        if (f[0]) r = r | (~x & ~y);
        return r;
    endfunction

    function automatic int chunks(input int k);
        int lanes [3] = '{1, 4, 8};
        return 8 / lanes[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input int k, input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] tf,
                      input logic [7:0] exp, input string tag);
        logic [7:0] old;
        int cyc;
        bit seen;
        bit held_ok;
        @(negedge clk);
        old = s_w[k];
        a_v = ta; b_v = tb_; func_v = tf; start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        a_v = 8'($urandom); b_v = 8'($urandom); func_v = 4'($urandom);
        chk({tag, ".busy"}, {31'd0, busy_w[k]}, 32'd1);
        cyc = 0; seen = 1'b0; held_ok = 1'b1;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done_w[k]) begin
                seen = 1'b1;
            end else begin
                if (s_w[k] !== old) held_ok = 1'b0;
                start_v[k] = 1'($urandom);
            end
        end
        start_v[k] = 1'b0;
        chk({tag, ".latency"}, cyc, chunks(k));
        chk({tag, ".s"}, {24'd0, s_w[k]}, {24'd0, exp});
        chk({tag, ".hold"}, {31'd0, held_ok}, 32'd1);
        chk({tag, ".busy_end"}, {31'd0, busy_w[k]}, 32'd0);
`ifdef GATE_EVAL_POPCNT_EN
        chk({tag, ".pop"}, {28'd0, pop_w[k]}, $countones(exp));
`endif
        @(posedge clk); #1;
        chk({tag, ".done_fall"}, {31'd0, done_w[k]}, 32'd0);
    endtask

    initial begin
        int c1;
        int c2;
        int dcount;
        start_v[0] = 1'b0; start_v[1] = 1'b0; start_v[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d.busy", k), {31'd0, busy_w[k]}, 32'd0);
            chk($sformatf("rst%0d.done", k), {31'd0, done_w[k]}, 32'd0);
            chk($sformatf("rst%0d.s", k), {24'd0, s_w[k]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Directed cases from the plan.
        op(0, 8'hA5, 8'h0F, FN_OR, 8'hAF, "or_l1");
        op(1, 8'hFF, 8'h3C, FN_NAND, 8'hC3, "nand_l4");
        op(2, 8'h00, 8'h00, FN_NOR, 8'hFF, "nor_l8");

        // Every truth table on the canonical operand pair.
        for (int f = 0; f < 16; f++) begin
            op(f % 3, 8'hCC, 8'hAA, 4'(f), model(8'hCC, 8'hAA, 4'(f)), $sformatf("exh_f%0d", f));
        end

        // Random operations across all three lane configurations.
        for (int i = 0; i < 18; i++) begin
            logic [7:0] ra, rb;
            logic [3:0] rf;
            int k;
            ra = 8'($urandom); rb = 8'($urandom); rf = 4'($urandom);
            k = int'($urandom_range(0, 2));
            op(k, ra, rb, rf, model(ra, rb, rf), $sformatf("rnd%0d", i));
        end

        // Back-to-back with start held high: XOR then AND.
        @(negedge clk);
        a_v = 8'h5A; b_v = 8'h33; func_v = FN_XOR; start_v[0] = 1'b1;
        @(posedge clk); #1;
        a_v = 8'hF0; b_v = 8'h3C; func_v = FN_AND;
        c1 = 0;
        while (!done_w[0] && c1 < 40) begin
            @(posedge clk); #1;
            c1++;
        end
        chk("b2b.lat1", c1, 8);
        chk("b2b.s1", {24'd0, s_w[0]}, {24'd0, 8'h5A ^ 8'h33});
        c2 = 0;
        do begin
            @(posedge clk); #1;
            c2++;
            if (c2 == 1) begin
                a_v = 8'($urandom); b_v = 8'($urandom); func_v = 4'($urandom);
            end
        end while (!done_w[0] && c2 < 40);
        chk("b2b.gap", c2, 9);
        chk("b2b.s2", {24'd0, s_w[0]}, {24'd0, 8'hF0 & 8'h3C});
        start_v[0] = 1'b0;
        @(posedge clk); #1;

        // Reset mid-RUN at idx=3 discards the operation.
        @(negedge clk);
        a_v = 8'h0F; b_v = 8'hF0; func_v = FN_OR; start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst.busy", {31'd0, busy_w[0]}, 32'd0);
        chk("midrst.done", {31'd0, done_w[0]}, 32'd0);
        chk("midrst.s", {24'd0, s_w[0]}, 32'd0);
`ifdef GATE_EVAL_POPCNT_EN
        chk("midrst.pop", {28'd0, pop_w[0]}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done_w[0]) dcount++;
        end
        chk("midrst.nodone", dcount, 0);
        chk("midrst.s_after", {24'd0, s_w[0]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
